asm_loader: RTL and testbench

Program loader for the nanoprocessor, and the inverse of the instruction disassembler. It receives ASCII assembly text one character at a time, for example from a UART receiver or a testbench file reader. Each line is parsed into a 12-bit instruction word (4-bit opcode, 8-bit operand) and written to program memory at an auto-incrementing address. Malformed lines are reported and dropped.

---
 rtl/asm_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_asm_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_loader.sv
// asm_loader: program loader for the nanoprocessor.
//
// Receives ASCII assembly text one character at a time, parses each line
// into a {opcode[3:0], operand[OPND_W-1:0]} instruction word and writes it
// to program memory at an auto-incrementing address. Malformed lines raise
// a one-cycle err_o pulse, are counted, and are dropped.
//
// Handshake: char_i is transferred on a rising clk edge where
// char_valid_i && char_ready_o. char_ready_o depends only on FSM state
// (low during the single EMIT cycle), never on char_valid_i. A character
// held valid while ready is low is taken, unchanged, on a later edge.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   char_i        ASCII character
//   char_valid_i  char_i valid
//   char_ready_o  loader can accept a character
//   addr_clr_i    synchronous clear of the write address (wins over increment)
//   instr_o       {opcode, operand}; holds its value between strobes
//   instr_addr_o  current write address
//   instr_we_o    one-cycle write strobe (EMIT state)
//   err_o         one-cycle pulse on a syntax error
//   err_count_o   erroneous-line count, saturating at 255
module asm_loader #(
    parameter int OPND_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          char_i,
    input  logic                char_valid_i,
    output logic                char_ready_o,
    input  logic                addr_clr_i,
    output logic [OPND_W+3:0]   instr_o,
    output logic [ADDR_W-1:0]   instr_addr_o,
    output logic                instr_we_o,
    output logic                err_o,
    output logic [7:0]          err_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_MNEM, S_SEP, S_OPND, S_TAIL, S_SKIP, S_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [23:0]         mnem_q, mnem_d;     // up to three folded letters, newest in [7:0]
    logic [1:0]          mcnt_q, mcnt_d;     // letters collected
    logic [3:0]          opc_q, opc_d;       // opcode latched when the mnemonic ends on a space
    logic [7:0]          opnd_q, opnd_d;     // up to two hex digits
    logic [1:0]          dcnt_q, dcnt_d;     // digits collected
    logic [OPND_W+3:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic [7:0]          errcnt_q, errcnt_d;

    // Character classification on the case-folded character.
    logic [7:0] ch;
    logic       is_letter, is_digit, is_hex, is_space, is_lf, is_cr, accept;
    logic [3:0] hex_val;

    always_comb begin
        ch = char_i;
        if (char_i >= 8'h61 && char_i <= 8'h7A) ch = char_i - 8'h20;
    end

    assign is_letter = (ch >= 8'h41) && (ch <= 8'h5A);
    assign is_digit  = (ch >= 8'h30) && (ch <= 8'h39);
    assign is_hex    = is_digit || ((ch >= 8'h41) && (ch <= 8'h46));
    assign hex_val   = is_digit ? ch[3:0] : ch[3:0] + 4'd9;   // 'A' = 0x41 -> 10
    assign is_space  = (ch == 8'h20);
    assign is_lf     = (ch == 8'h0A);
    assign is_cr     = (ch == 8'h0D);
    assign accept    = char_valid_i && char_ready_o;

    // Mnemonic lookup on the letters collected so far.
    logic       lut_valid;
    logic [3:0] lut_op;

    always_comb begin
        lut_valid = 1'b0;
        lut_op    = 4'h0;
        if (mcnt_q == 2'd2) begin
            lut_valid = (mnem_q[15:0] == "OR");
            lut_op    = 4'h3;
        end else if (mcnt_q == 2'd3) begin
            lut_valid = 1'b1;
            case (mnem_q)
                "NOP":   lut_op = 4'h0;
                "XOR":   lut_op = 4'h1;
                "AND":   lut_op = 4'h2;
                "ADD":   lut_op = 4'h4;
                "ADC":   lut_op = 4'h5;
                "SUB":   lut_op = 4'h6;
                "SBC":   lut_op = 4'h7;
                "ROL":   lut_op = 4'h8;
                "ROR":   lut_op = 4'h9;
                "LDA":   lut_op = 4'hA;
                "STA":   lut_op = 4'hB;
                "OUT":   lut_op = 4'hC;
                "JMP":   lut_op = 4'hD;
                "JNC":   lut_op = 4'hE;
                "JNZ":   lut_op = 4'hF;
                default: lut_valid = 1'b0;
            endcase
        end
    end

    // Next-state logic. The instruction word is assembled on the LF edge so
    // instr_o is already valid during the EMIT cycle.
    always_comb begin
        state_d = state_q;
        mnem_d  = mnem_q;
        mcnt_d  = mcnt_q;
        opc_d   = opc_q;
        opnd_d  = opnd_q;
        dcnt_d  = dcnt_q;
        instr_d = instr_q;
        err_d   = 1'b0;

        if (state_q == S_EMIT) begin
            state_d = S_IDLE;
        end else if (accept && !is_cr) begin
            case (state_q)
                S_IDLE: begin
                    if (is_letter) begin
                        state_d = S_MNEM;
                        mnem_d  = {16'h0000, ch};
                        mcnt_d  = 2'd1;
                        opnd_d  = 8'h00;
                        dcnt_d  = 2'd0;
                    end else if (!is_space && !is_lf) begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end
                S_MNEM: begin
                    if (is_letter) begin
                        if (mcnt_q == 2'd3) begin
                            state_d = S_SKIP;
                            err_d   = 1'b1;
                        end else begin
                            mnem_d = {mnem_q[15:0], ch};
                            mcnt_d = mcnt_q + 2'd1;
                        end
                    end else if (is_space || is_lf) begin
                        if (!lut_valid) begin
                            err_d   = 1'b1;
                            state_d = is_lf ? S_IDLE : S_SKIP;
                        end else if (is_space) begin
                            opc_d   = lut_op;
                            state_d = S_SEP;
                        end else begin
                            instr_d = {lut_op, {OPND_W{1'b0}}};
                            state_d = S_EMIT;
                        end
                    end else begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end
                S_SEP: begin
                    if (is_hex) begin
                        opnd_d  = {4'h0, hex_val};
                        dcnt_d  = 2'd1;
                        state_d = S_OPND;
                    end else if (is_lf) begin
                        instr_d = {opc_q, OPND_W'(opnd_q)};
                        state_d = S_EMIT;
                    end else if (!is_space) begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end
                S_OPND: begin
                    if (is_hex) begin
                        if (dcnt_q == 2'd2) begin
                            state_d = S_SKIP;
                            err_d   = 1'b1;
                        end else begin
                            opnd_d = {opnd_q[3:0], hex_val};
                            dcnt_d = 2'd2;
                        end
                    end else if (is_space) begin
                        state_d = S_TAIL;
                    end else if (is_lf) begin
                        instr_d = {opc_q, OPND_W'(opnd_q)};
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end
                S_TAIL: begin
                    if (is_lf) begin
                        instr_d = {opc_q, OPND_W'(opnd_q)};
                        state_d = S_EMIT;
                    end else if (!is_space) begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end
                S_SKIP: begin
                    if (is_lf) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Clear wins over the post-EMIT increment; the strobe itself already
    // used the old address.
    always_comb begin
        addr_d = addr_q;
        if (addr_clr_i)            addr_d = '0;
        else if (state_q == S_EMIT) addr_d = addr_q + ADDR_W'(1);
    end

    assign errcnt_d = (err_d && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mnem_q   <= '0;
            mcnt_q   <= '0;
            opc_q    <= '0;
            opnd_q   <= '0;
            dcnt_q   <= '0;
            instr_q  <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mnem_q   <= mnem_d;
            mcnt_q   <= mcnt_d;
            opc_q    <= opc_d;
            opnd_q   <= opnd_d;
            dcnt_q   <= dcnt_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign char_ready_o = (state_q != S_EMIT);
    assign instr_we_o   = (state_q == S_EMIT);
    assign instr_o      = instr_q;
    assign instr_addr_o = addr_q;
    assign err_o        = err_q;
    assign err_count_o  = errcnt_q;

endmodule

// File: tb/tb_asm_loader.sv
// Bench for asm_loader: directed lines from the test plan plus random lines,
// each checked character by character against a line-level grammar model.
module tb_asm_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_i = 8'h00;
    logic        char_valid_i = 1'b0;
    logic        char_ready_o;
    logic        addr_clr_i = 1'b0;
    logic [11:0] instr_o;
    logic [7:0]  instr_addr_o;
    logic        instr_we_o;
    logic        err_o;
    logic [7:0]  err_count_o;

    asm_loader #(.OPND_W(8), .ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .addr_clr_i   (addr_clr_i),
        .instr_o      (instr_o),
        .instr_addr_o (instr_addr_o),
        .instr_we_o   (instr_we_o),
        .err_o        (err_o),
        .err_count_o  (err_count_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    // model state
    logic [7:0]  model_addr = 8'h00;
    int          model_errs = 0;
    bit          prev_wr = 1'b0;
    bit          clr_pending = 1'b0;
    logic [11:0] last_instr = 12'h000;
    logic [7:0]  last_addr = 8'h00;

    string names[16] = '{"NOP","XOR","AND","OR","ADD","ADC","SUB","SBC",
                         "ROL","ROR","LDA","STA","OUT","JMP","JNC","JNZ"};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] fold(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction
    function automatic bit is_let(input logic [7:0] c);
        return c >= 8'h41 && c <= 8'h5A;
    endfunction
    function automatic bit is_hx(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
    endfunction
    function automatic int hx(input logic [7:0] c);
        return (c <= 8'h39) ? int'(c) - 48 : int'(c) - 55;
    endfunction

    // Parses one line (without its LF). err_idx is the position, in the
    // sent character sequence (LF at index s.len()), of the first character
    // that breaks the grammar, or -1.
    function automatic void model_line(input string s, output int err_idx,
                                       output bit wr, output logic [11:0] instr);
        logic [7:0] ch[$];
        int pos[$];
        int k, m0, d, op, val;
        string mn;
        err_idx = -1; wr = 1'b0; instr = 12'h000;
        for (int i = 0; i < s.len(); i++)
            if (s[i] != 8'h0D) begin ch.push_back(fold(s[i])); pos.push_back(i); end
        ch.push_back(8'h0A); pos.push_back(s.len());
        k = 0;
        while (ch[k] == 8'h20) k++;
        if (ch[k] == 8'h0A) return;
        if (!is_let(ch[k])) begin err_idx = pos[k]; return; end
        m0 = k; mn = "";
        while (is_let(ch[k]) && (k - m0) < 3) begin mn = $sformatf("%s%c", mn, ch[k]); k++; end
        if (ch[k] != 8'h20 && ch[k] != 8'h0A) begin err_idx = pos[k]; return; end
        op = -1;
        for (int i = 0; i < 16; i++) if (names[i] == mn) op = i;
        if (op < 0) begin err_idx = pos[k]; return; end
        instr = {op[3:0], 8'h00};
        if (ch[k] == 8'h0A) begin wr = 1'b1; return; end
        while (ch[k] == 8'h20) k++;
        if (ch[k] == 8'h0A) begin wr = 1'b1; return; end
        if (!is_hx(ch[k])) begin err_idx = pos[k]; return; end
        val = 0; d = 0;
        while (is_hx(ch[k])) begin
            if (d == 2) begin err_idx = pos[k]; return; end
            val = val * 16 + hx(ch[k]); d++; k++;
        end
        while (ch[k] == 8'h20) k++;
        if (ch[k] != 8'h0A) begin err_idx = pos[k]; return; end
        instr = {op[3:0], val[7:0]};
        wr = 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_char(input logic [7:0] c, input bit exp_err, input bit exp_wr,
                             input logic [11:0] exp_instr);
        int waits;
        if (prev_wr) chk("ready_low_in_emit", char_ready_o, 1'b0);
        char_i = c;
        char_valid_i = 1'b1;
        waits = 0;
        while (char_ready_o !== 1'b1 && waits < 4) begin
            @(negedge clk);
            addr_clr_i = 1'b0;
            waits++;
        end
        if (prev_wr) begin
            chk("emit_stall_cycles", waits, 1);
            chk("addr_after_emit", instr_addr_o, model_addr);
            chk("we_after_emit", instr_we_o, 1'b0);
            prev_wr = 1'b0;
        end else begin
            chk("ready_stall", waits, 0);
        end
        @(negedge clk);
        chk("err_pulse", err_o, exp_err);
        chk("write_strobe", instr_we_o, exp_wr);
        if (exp_wr) begin
            chk("instr_word", instr_o, exp_instr);
            chk("write_addr", instr_addr_o, model_addr);
            last_instr = instr_o;
            last_addr  = instr_addr_o;
            if (clr_pending) begin
                addr_clr_i  = 1'b1;
                clr_pending = 1'b0;
                model_addr  = 8'h00;
            end else begin
                model_addr = model_addr + 8'd1;
            end
            prev_wr = 1'b1;
        end else begin
            chk("addr_stable", instr_addr_o, model_addr);
        end
    endtask

    task automatic send_line(input string s);
        int err_idx;
        bit wr;
        logic [11:0] ins;
        logic [7:0] c;
        model_line(s, err_idx, wr, ins);
        for (int i = 0; i <= s.len(); i++) begin
            c = (i == s.len()) ? 8'h0A : s[i];
            send_char(c, i == err_idx, (i == s.len()) && wr, ins);
        end
        if (err_idx >= 0 && model_errs < 255) model_errs++;
        chk("err_count", err_count_o, model_errs);
    endtask

    task automatic finish_stream();
        if (prev_wr) begin
            char_valid_i = 1'b0;
            @(negedge clk);
            addr_clr_i = 1'b0;
            chk("idle_we", instr_we_o, 1'b0);
            chk("idle_ready", char_ready_o, 1'b1);
            chk("idle_addr", instr_addr_o, model_addr);
            prev_wr = 1'b0;
        end
        char_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        finish_stream();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        addr_clr_i = 1'b0;
        model_addr = 8'h00;
        model_errs = 0;
        chk("rst_ready", char_ready_o, 1'b1);
        chk("rst_we", instr_we_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_errcnt", err_count_o, 8'h00);
        chk("rst_addr", instr_addr_o, 8'h00);
        chk("rst_instr", instr_o, 12'h000);
    endtask

    function automatic string app(input string s, input logic [7:0] c);
        string r;
        r = s;
        if ($urandom_range(0, 9) == 0) r = $sformatf("%s%c", r, 8'h0D);
        return $sformatf("%s%c", r, c);
    endfunction

    function automatic string rand_line();
        string s, nm, gb;
        logic [7:0] c;
        int v;
        s = "";
        if ($urandom_range(0, 9) < 7) begin
            repeat ($urandom_range(0, 2)) s = app(s, 8'h20);
            nm = names[$urandom_range(0, 15)];
            for (int i = 0; i < nm.len(); i++) begin
                c = nm[i];
                if ($urandom_range(0, 1) == 1) c = c + 8'h20;
                s = app(s, c);
            end
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 2)) s = app(s, 8'h20);
                repeat ($urandom_range(1, 3)) begin
                    v = $urandom_range(0, 15);
                    c = (v < 10) ? 8'h30 + 8'(v) : 8'h41 + 8'(v - 10);
                    if (v >= 10 && $urandom_range(0, 1) == 1) c = c + 8'h20;
                    s = app(s, c);
                end
            end
            repeat ($urandom_range(0, 2)) s = app(s, 8'h20);
        end else begin
            gb = "AZf3 #or5G";
            repeat ($urandom_range(1, 7)) s = app(s, gb[$urandom_range(0, gb.len() - 1)]);
        end
        return s;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        do_reset();

        // LDA with two-digit operand, then next address
        send_line("LDA 3F");
        chk("lda_instr", last_instr, 12'hA3F);
        chk("lda_addr", last_addr, 8'h00);
        send_line("nop");
        chk("second_addr", last_addr, 8'h01);

        // lowercase two-letter mnemonic, single digit, spaces and CR
        do_reset();
        send_line($sformatf("  or 5 %c", 8'h0D));
        chk("or_instr", last_instr, 12'h305);
        chk("or_addr", last_addr, 8'h00);
        send_line("NOP");
        chk("nop_instr", last_instr, 12'h000);
        chk("nop_addr", last_addr, 8'h01);
        chk("or_no_err", err_count_o, 8'h00);

        // unknown mnemonic, then lowercase hex
        do_reset();
        send_line("XYZ 01");
        chk("xyz_errcnt", err_count_o, 8'h01);
        send_line("JNZ ff");
        chk("jnz_instr", last_instr, 12'hFFF);
        chk("jnz_addr", last_addr, 8'h00);

        // third digit and fourth letter
        do_reset();
        send_line("ADD 123");
        send_line("ADDX");
        chk("two_errs", err_count_o, 8'h02);

        // 257 back-to-back lines with valid held high: address wraps
        do_reset();
        for (int i = 0; i < 257; i++) begin
            send_line("OUT 0");
            if (i == 255) chk("wrap_last_addr", last_addr, 8'hFF);
        end
        chk("wrap_addr", last_addr, 8'h00);
        chk("out_instr", last_instr, 12'hC00);

        // reset mid-line discards the partial line
        finish_stream();
        send_char("S", 1'b0, 1'b0, 12'h000);
        send_char("T", 1'b0, 1'b0, 12'h000);
        send_char("A", 1'b0, 1'b0, 12'h000);
        send_char(" ", 1'b0, 1'b0, 12'h000);
        send_char("4", 1'b0, 1'b0, 12'h000);
        do_reset();
        send_line("JMP 10");
        chk("jmp_instr", last_instr, 12'hD10);
        chk("jmp_addr", last_addr, 8'h00);

        // address clear during EMIT: that write keeps old address
        clr_pending = 1'b1;
        send_line("LDA 1");
        chk("clr_write_addr", last_addr, 8'h01);
        send_line("ROL 7");
        chk("after_clr_addr", last_addr, 8'h00);
        chk("rol_instr", last_instr, 12'h807);

        // random lines
        do_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) clr_pending = 1'b1;
            send_line(rand_line());
        end

        // error counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) send_line("#");
        chk("err_saturate", err_count_o, 8'hFF);
        finish_stream();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
